// File: rtl/nm_compact_fifo_pkg.sv
// Shared sizing helpers and lane counting for the N-to-M compacting FIFO.
package nm_compact_fifo_pkg;

  localparam int MAX_LANES = 64;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int popcount(input logic [MAX_LANES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/nm_compact_fifo_lane_compactor.sv
// Packs the valid input lanes, in ascending lane order, into the low output slots.
module nm_compact_fifo_lane_compactor
  import nm_compact_fifo_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CW         = $clog2(N_IN + 1)
) (
  input  logic [0:N_IN-1][DATA_WIDTH-1:0] data_i,
  input  logic [N_IN-1:0]                 wr_en_i,
  output logic [0:N_IN-1][DATA_WIDTH-1:0] lanes_o,
  output logic [CW-1:0]                   wcnt_o
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  // Prefix-sum scatter: each valid lane lands at the count of valid lanes below it.
  always_comb begin
    logic [CW-1:0] pos;
    lanes_o = '0;
    pos     = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (wr_en_i[i]) begin
        lanes_o[IW'(pos)] = data_i[i];
        pos               = pos + CW'(1);
      end else begin
        pos = pos;
      end
    end
  end

  assign wcnt_o = CW'(popcount(MAX_LANES'(wr_en_i)));

endmodule

// File: rtl/nm_compact_fifo.sv
// Sparse N_IN-lane to N_OUT-lane compacting FIFO over a circular element buffer.
module nm_compact_fifo
  import nm_compact_fifo_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 1,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [0:N_IN-1][DATA_WIDTH-1:0]  data_i,
  input  logic [N_IN-1:0]                  wr_en_i,
  output logic                             wr_accept_o,
  output logic [0:N_OUT-1][DATA_WIDTH-1:0] data_o,
  output logic [N_OUT-1:0]                 out_valid_o,
  input  logic                             out_ready_i,
  output logic [lvl_w(DEPTH)-1:0]          level_o,
  output logic                             full_o,
  output logic                             empty_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam int CW = $clog2(N_IN + 1);

  typedef logic [DATA_WIDTH-1:0] elem_t;

  elem_t                         mem_q [DEPTH];
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                 level_q, level_d;
  logic [LW-1:0]                 free_s, wcnt_lvl_s, rcnt_lvl_s;
  logic [0:N_IN-1][DATA_WIDTH-1:0] lanes_s;
  logic [CW-1:0]                 wcnt_s;
  logic                          accept_s, pop_s;

  nm_compact_fifo_lane_compactor #(
    .N_IN      (N_IN),
    .DATA_WIDTH(DATA_WIDTH),
    .CW        (CW)
  ) u_compactor (
    .data_i (data_i),
    .wr_en_i(wr_en_i),
    .lanes_o(lanes_s),
    .wcnt_o (wcnt_s)
  );

  // Free space deliberately ignores a same-cycle pop, keeping out_ready_i off the accept path.
  assign wcnt_lvl_s = LW'(wcnt_s);
  assign free_s     = LW'(DEPTH) - level_q;
  assign rcnt_lvl_s = (level_q < LW'(N_OUT)) ? level_q : LW'(N_OUT);
  assign accept_s   = !rst_i && (wcnt_s != '0) && (wcnt_lvl_s <= free_s);
  assign pop_s      = out_ready_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PW'(wcnt_s);
      level_d  = level_d + wcnt_lvl_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(rcnt_lvl_s);
      level_d  = level_d - rcnt_lvl_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < N_IN; j++) begin
      if (accept_s && (CW'(j) < wcnt_s)) begin
        mem_q[wr_ptr_q + PW'(j)] <= lanes_s[j];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      out_valid_o[k] = (LW'(k) < rcnt_lvl_s);
      data_o[k]      = mem_q[rd_ptr_q + PW'(k)];
    end
  end

  assign wr_accept_o = accept_s;
  assign level_o     = level_q;
  assign full_o      = (level_q == LW'(DEPTH));
  assign empty_o     = (level_q == '0);

endmodule

// File: tb/tb_nm_compact_fifo.sv
// Self-checking bench: directed tables/sequences plus a queue-based random scoreboard.
module tb_nm_compact_fifo;

  localparam int NI  = 4;
  localparam int DW  = 8;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [0:NI-1][DW-1:0] d1, d2;
  logic [NI-1:0]         we1, we2;
  logic                  acc1, acc2, rdy1, rdy2;
  logic [0:0][DW-1:0]    do1;
  logic [0:1][DW-1:0]    do2;
  logic [0:0]            ov1;
  logic [1:0]            ov2;
  logic [4:0]            lvl1, lvl2;
  logic                  full1, full2, empty1, empty2;

  nm_compact_fifo #(.N_IN(NI), .N_OUT(1), .DATA_WIDTH(DW), .DEPTH(DEP)) u1 (
    .clk_i(clk), .rst_i(rst), .data_i(d1), .wr_en_i(we1), .wr_accept_o(acc1),
    .data_o(do1), .out_valid_o(ov1), .out_ready_i(rdy1), .level_o(lvl1),
    .full_o(full1), .empty_o(empty1)
  );

  nm_compact_fifo #(.N_IN(NI), .N_OUT(2), .DATA_WIDTH(DW), .DEPTH(DEP)) u2 (
    .clk_i(clk), .rst_i(rst), .data_i(d2), .wr_en_i(we2), .wr_accept_o(acc2),
    .data_o(do2), .out_valid_o(ov2), .out_ready_i(rdy2), .level_o(lvl2),
    .full_o(full2), .empty_o(empty2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    we1  = '0; we2 = '0; rdy1 = 1'b0; rdy2 = 1'b0;
    d1   = '0; d2  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NI-1:0] we;
    logic          rdy;
    logic          exp_acc;
    int            exp_lvl;
    logic          exp_full;
  } vec_t;

  vec_t tbl[12];
  logic [DW-1:0] mq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Full/reject/partial-fit walk on the two-lane-drain instance.
    tbl[0]  = '{4'hF, 1'b0, 1'b1, 4,  1'b0};
    tbl[1]  = '{4'hF, 1'b0, 1'b1, 8,  1'b0};
    tbl[2]  = '{4'hF, 1'b0, 1'b1, 12, 1'b0};
    tbl[3]  = '{4'hF, 1'b0, 1'b1, 16, 1'b1};
    tbl[4]  = '{4'hF, 1'b0, 1'b0, 16, 1'b1};
    tbl[5]  = '{4'h0, 1'b1, 1'b0, 14, 1'b0};
    tbl[6]  = '{4'h3, 1'b0, 1'b1, 16, 1'b1};
    tbl[7]  = '{4'h0, 1'b1, 1'b0, 14, 1'b0};
    tbl[8]  = '{4'h1, 1'b0, 1'b1, 15, 1'b0};
    tbl[9]  = '{4'h3, 1'b0, 1'b0, 15, 1'b0};
    tbl[10] = '{4'h3, 1'b1, 1'b0, 13, 1'b0};
    tbl[11] = '{4'h3, 1'b0, 1'b1, 15, 1'b0};

    // Reset state, with a write request pending during reset.
    rst = 1'b1;
    we1 = 4'hF; we2 = 4'hF; rdy1 = 1'b0; rdy2 = 1'b0; d1 = '0; d2 = '0;
    #3;
    chk("rst_accept", 32'(acc2), 32'd0);
    chk("rst_valid", 32'(ov2), 32'd0);
    chk("rst_level", 32'(lvl2), 32'd0);
    chk("rst_empty", 32'(empty2), 32'd1);
    chk("rst_full", 32'(full2), 32'd0);
    do_reset();

    // Sparse compaction on the single-lane-drain instance: lanes 0 and 2.
    we1 = 4'b0101; rdy1 = 1'b1;
    d1[0] = 8'hA0; d1[1] = 8'hA1; d1[2] = 8'hA2; d1[3] = 8'hA3;
    #1;
    chk("sparse_accept", 32'(acc1), 32'd1);
    chk("sparse_valid0", 32'(ov1), 32'd0);
    @(negedge clk);
    we1 = '0;
    #1;
    chk("sparse_lvl2", 32'(lvl1), 32'd2);
    chk("sparse_valid1", 32'(ov1), 32'd1);
    chk("sparse_data_a0", 32'(do1[0]), 32'hA0);
    @(negedge clk);
    chk("sparse_lvl1", 32'(lvl1), 32'd1);
    chk("sparse_data_a2", 32'(do1[0]), 32'hA2);
    @(negedge clk);
    chk("sparse_lvl0", 32'(lvl1), 32'd0);
    chk("sparse_empty", 32'(empty1), 32'd1);
    chk("sparse_valid_off", 32'(ov1), 32'd0);
    rdy1 = 1'b0;

    // Multi-lane drain.
    do_reset();
    we2 = 4'hF; d2[0] = 8'hB0; d2[1] = 8'hB1; d2[2] = 8'hB2; d2[3] = 8'hB3;
    @(negedge clk);
    we2 = '0;
    chk("drain_lvl4", 32'(lvl2), 32'd4);
    chk("drain_valid", 32'(ov2), 32'd3);
    chk("drain_b0", 32'(do2[0]), 32'hB0);
    chk("drain_b1", 32'(do2[1]), 32'hB1);
    rdy2 = 1'b1;
    @(negedge clk);
    chk("drain_lvl2", 32'(lvl2), 32'd2);
    chk("drain_b2", 32'(do2[0]), 32'hB2);
    chk("drain_b3", 32'(do2[1]), 32'hB3);
    @(negedge clk);
    chk("drain_lvl0", 32'(lvl2), 32'd0);
    chk("drain_valid_off", 32'(ov2), 32'd0);
    chk("drain_empty", 32'(empty2), 32'd1);

    // Table: fill, reject, partial fit.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      we2  = tbl[i].we;
      rdy2 = tbl[i].rdy;
      for (int l = 0; l < NI; l++) d2[l] = 8'($urandom);
      #1;
      chk($sformatf("tbl%0d_accept", i), 32'(acc2), 32'(tbl[i].exp_acc));
      @(negedge clk);
      chk($sformatf("tbl%0d_level", i), 32'(lvl2), 32'(tbl[i].exp_lvl));
      chk($sformatf("tbl%0d_full", i), 32'(full2), 32'(tbl[i].exp_full));
    end

    // Random traffic against a queue model.
    do_reset();
    mq.delete();
    begin
      logic [NI-1:0]         we_h;
      logic [0:NI-1][DW-1:0] d_h;
      logic [DW-1:0]         seq;
      bit                    hold;
      int                    wc, rc;
      bit                    exp_acc;
      hold = 1'b0;
      seq  = 8'd0;
      we_h = '0;
      d_h  = '0;
      for (int c = 0; c < 10000; c++) begin
        if (!hold) begin
          we_h = 4'($urandom_range(0, 15));
          for (int l = 0; l < NI; l++) begin
            d_h[l] = seq;
            seq    = seq + 8'd1;
          end
        end
        we2  = we_h;
        d2   = d_h;
        rdy2 = (((c / 500) % 2) == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) < 3);
        #1;
        wc      = $countones(we_h);
        exp_acc = (wc != 0) && (wc <= DEP - mq.size());
        rc      = (mq.size() < 2) ? mq.size() : 2;
        chk("rand_accept", 32'(acc2), 32'(exp_acc));
        chk("rand_valid", 32'(ov2), 32'((1 << rc) - 1));
        for (int k = 0; k < rc; k++) chk("rand_data", 32'(do2[k]), 32'(mq[k]));
        chk("rand_level", 32'(lvl2), 32'(mq.size()));
        chk("rand_full", 32'(full2), 32'(mq.size() == DEP));
        chk("rand_empty", 32'(empty2), 32'(mq.size() == 0));
        chk("rand_level_bound", 32'(lvl2 <= 5'd16), 32'd1);
        if (rdy2 && (rc != 0)) begin
          for (int k = 0; k < rc; k++) void'(mq.pop_front());
        end
        if (exp_acc) begin
          for (int l = 0; l < NI; l++) if (we_h[l]) mq.push_back(d_h[l]);
        end
        hold = (wc != 0) && !exp_acc;
        @(negedge clk);
      end
    end

    // Async reset mid-stream at level 7.
    rdy2 = 1'b0;
    do_reset();
    we2 = 4'hF;
    @(negedge clk);
    we2 = 4'b0111;
    @(negedge clk);
    we2 = '0;
    chk("arst_pre_level", 32'(lvl2), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ov2), 32'd0);
    chk("arst_level", 32'(lvl2), 32'd0);
    chk("arst_empty", 32'(empty2), 32'd1);
    we2 = 4'hF;
    #1;
    chk("arst_accept", 32'(acc2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    we2 = 4'b0001; d2 = '0; d2[0] = 8'hC0;
    #1;
    chk("post_accept", 32'(acc2), 32'd1);
    @(negedge clk);
    we2 = '0;
    chk("post_valid", 32'(ov2), 32'd1);
    chk("post_data_c0", 32'(do2[0]), 32'hC0);
    chk("post_level", 32'(lvl2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
